// File: rtl/lock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lock_pkg: shared state encoding and constants for the lock cycle.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lock_pkg;

    localparam int CNT_W              = 10;
    localparam int EVAC_SECONDS_DEF   = 7;
    localparam int PRESS_SECONDS_DEF  = 5;

    typedef enum logic [2:0] {
        PRESSED      = 3'd0,
        EVAC_START   = 3'd1,
        EVACUATING   = 3'd2,
        DEPRESSED    = 3'd3,
        PRESS_START  = 3'd4,
        PRESSURIZING = 3'd5,
        FAULT        = 3'd6
    } lock_state_e;

    function automatic logic doors_closed(input logic inner_open, input logic outer_open);
        return !inner_open && !outer_open;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_cycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lock_cycle_ctrl_if: switch, door-sensor, counter and actuator bus.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface lock_cycle_ctrl_if #(
    parameter int CNT_W = lock_pkg::CNT_W
);
    logic             evacSw;
    logic             pressSw;
    logic             innerOpen;
    logic             outerOpen;
    logic             countDone;
    logic             beginCount;
    logic [CNT_W-1:0] counterSeconds;
    logic             pumpOn;
    logic             ventOn;
    logic             innerEn;
    logic             outerEn;
    logic             busy;
    logic             reqReject;
    logic             fault;

    modport master (
        output evacSw, pressSw, innerOpen, outerOpen, countDone,
        input  beginCount, counterSeconds, pumpOn, ventOn,
               innerEn, outerEn, busy, reqReject, fault
    );

    modport slave (
        input  evacSw, pressSw, innerOpen, outerOpen, countDone,
        output beginCount, counterSeconds, pumpOn, ventOn,
               innerEn, outerEn, busy, reqReject, fault
    );
endinterface
`default_nettype wire

// File: rtl/lock_cycle_ctrl_rise_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rise_edge: registered rising-edge detector, one-cycle output pulse.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rise_edge (
    input  wire logic Clock,
    input  wire logic Reset,
    input  wire logic i_sig,
    output logic      o_pulse
);
    logic hist_q, hist_d;
    logic pulse_q, pulse_d;

    always_comb begin
        hist_d  = i_sig;
        pulse_d = i_sig && !hist_q;
    end

    // History resets high so a level already present at reset is not an edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hist_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;
endmodule
`default_nettype wire

// File: rtl/lock_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lock_cycle_ctrl: chamber-lock sequencer driving the seconds counter. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lock_cycle_ctrl
    import lock_pkg::*;
#(
    parameter int CNT_W         = lock_pkg::CNT_W,
    parameter int EVAC_SECONDS  = EVAC_SECONDS_DEF,
    parameter int PRESS_SECONDS = PRESS_SECONDS_DEF
) (
    input  wire logic        Clock,
    input  wire logic        Reset,
    lock_cycle_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] C_EVAC_LOAD  = CNT_W'(EVAC_SECONDS);
    localparam logic [CNT_W-1:0] C_PRESS_LOAD = CNT_W'(PRESS_SECONDS);

    logic w_ev_req, w_pr_req;
    logic w_doors_closed, w_any_req, w_ev_only, w_pr_only;

    lock_state_e      state_q, state_d;
    logic             begin_count_q, begin_count_d;
    logic [CNT_W-1:0] counter_seconds_q, counter_seconds_d;
    logic             pump_on_q, pump_on_d;
    logic             vent_on_q, vent_on_d;
    logic             inner_en_q, inner_en_d;
    logic             outer_en_q, outer_en_d;
    logic             busy_q, busy_d;
    logic             req_reject_q, req_reject_d;
    logic             fault_q, fault_d;

    rise_edge u_ev_edge (.Clock(Clock), .Reset(Reset), .i_sig(bus.evacSw),  .o_pulse(w_ev_req));
    rise_edge u_pr_edge (.Clock(Clock), .Reset(Reset), .i_sig(bus.pressSw), .o_pulse(w_pr_req));

    always_comb begin
        w_doors_closed = doors_closed(bus.innerOpen, bus.outerOpen);
        w_any_req      = w_ev_req || w_pr_req;
        w_ev_only      = w_ev_req && !w_pr_req;
        w_pr_only      = w_pr_req && !w_ev_req;
        state_d        = state_q;
        req_reject_d   = 1'b0;

        // Door checks outrank countDone in every active state.
        case (state_q)
            PRESSED: begin
                if (w_ev_only && w_doors_closed) state_d = EVAC_START;
                else                             req_reject_d = w_any_req;
            end
            EVAC_START: begin
                req_reject_d = w_any_req;
                state_d      = w_doors_closed ? EVACUATING : FAULT;
            end
            EVACUATING: begin
                req_reject_d = w_any_req;
                if (!w_doors_closed)    state_d = FAULT;
                else if (bus.countDone) state_d = DEPRESSED;
            end
            DEPRESSED, FAULT: begin
                if (w_pr_only && w_doors_closed) state_d = PRESS_START;
                else                             req_reject_d = w_any_req;
            end
            PRESS_START: begin
                req_reject_d = w_any_req;
                state_d      = w_doors_closed ? PRESSURIZING : FAULT;
            end
            PRESSURIZING: begin
                req_reject_d = w_any_req;
                if (!w_doors_closed)    state_d = FAULT;
                else if (bus.countDone) state_d = PRESSED;
            end
            default: state_d = FAULT;
        endcase

        // Moore outputs are registered from the next state so they align with it.
        begin_count_d     = 1'b0;
        counter_seconds_d = counter_seconds_q;
        pump_on_d         = 1'b0;
        vent_on_d         = 1'b0;
        inner_en_d        = 1'b0;
        outer_en_d        = 1'b0;
        busy_d            = 1'b0;
        fault_d           = 1'b0;
        case (state_d)
            PRESSED:      inner_en_d = 1'b1;
            EVAC_START: begin
                begin_count_d     = 1'b1;
                counter_seconds_d = C_EVAC_LOAD;
                busy_d            = 1'b1;
            end
            EVACUATING: begin
                pump_on_d = 1'b1;
                busy_d    = 1'b1;
            end
            DEPRESSED:    outer_en_d = 1'b1;
            PRESS_START: begin
                begin_count_d     = 1'b1;
                counter_seconds_d = C_PRESS_LOAD;
                busy_d            = 1'b1;
            end
            PRESSURIZING: begin
                vent_on_d = 1'b1;
                busy_d    = 1'b1;
            end
            default:      fault_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q           <= PRESSED;
            begin_count_q     <= 1'b0;
            counter_seconds_q <= '0;
            pump_on_q         <= 1'b0;
            vent_on_q         <= 1'b0;
            inner_en_q        <= 1'b1;
            outer_en_q        <= 1'b0;
            busy_q            <= 1'b0;
            req_reject_q      <= 1'b0;
            fault_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            begin_count_q     <= begin_count_d;
            counter_seconds_q <= counter_seconds_d;
            pump_on_q         <= pump_on_d;
            vent_on_q         <= vent_on_d;
            inner_en_q        <= inner_en_d;
            outer_en_q        <= outer_en_d;
            busy_q            <= busy_d;
            req_reject_q      <= req_reject_d;
            fault_q           <= fault_d;
        end
    end

    assign bus.beginCount     = begin_count_q;
    assign bus.counterSeconds = counter_seconds_q;
    assign bus.pumpOn         = pump_on_q;
    assign bus.ventOn         = vent_on_q;
    assign bus.innerEn        = inner_en_q;
    assign bus.outerEn        = outer_en_q;
    assign bus.busy           = busy_q;
    assign bus.reqReject      = req_reject_q;
    assign bus.fault          = fault_q;
endmodule
`default_nettype wire

// File: tb/tb_lock_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lock_cycle_ctrl: directed self-checking bench for lock_cycle_ctrl.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lock_cycle_ctrl;
    localparam int CNT_W = 10;

    logic Clock;
    logic Reset;
    int   total;
    int   bad;

    lock_cycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    lock_cycle_ctrl #(
        .CNT_W(CNT_W), .EVAC_SECONDS(7), .PRESS_SECONDS(5)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.evacSw = 1'b1;  // held through reset: must not become a request
        bus.pressSw = 1'b0; bus.innerOpen = 1'b0; bus.outerOpen = 1'b0; bus.countDone = 1'b0;
        tick(); tick();
        total++; if (bus.innerEn !== 1'b1) begin bad++; $display("FAIL rst_innerEn got %b want 1", bus.innerEn); end
        total++; if ({bus.outerEn, bus.beginCount, bus.pumpOn, bus.ventOn, bus.busy, bus.reqReject, bus.fault} !== 7'b0)
            begin bad++; $display("FAIL rst_outputs got %b want 0000000", {bus.outerEn, bus.beginCount, bus.pumpOn, bus.ventOn, bus.busy, bus.reqReject, bus.fault}); end
        total++; if (bus.counterSeconds !== 10'd0) begin bad++; $display("FAIL rst_secs got %0d want 0", bus.counterSeconds); end
        Reset = 1'b1;
        tick(); tick(); tick();
        total++; if (bus.beginCount !== 1'b0 || bus.reqReject !== 1'b0 || bus.innerEn !== 1'b1)
            begin bad++; $display("FAIL rst_held_sw got begin=%b rej=%b inner=%b want 0 0 1", bus.beginCount, bus.reqReject, bus.innerEn); end
        bus.evacSw = 1'b0;
        tick();
    endtask

    task automatic test_evac_cycle();
        bus.evacSw = 1'b1;
        tick();
        total++; if (bus.beginCount !== 1'b0) begin bad++; $display("FAIL evac_n1_begin got %b want 0", bus.beginCount); end
        tick();
        total++; if (bus.beginCount !== 1'b1) begin bad++; $display("FAIL evac_begin got %b want 1", bus.beginCount); end
        total++; if (bus.counterSeconds !== 10'd7) begin bad++; $display("FAIL evac_secs got %0d want 7", bus.counterSeconds); end
        total++; if (bus.busy !== 1'b1 || bus.innerEn !== 1'b0) begin bad++; $display("FAIL evac_start got busy=%b inner=%b want 1 0", bus.busy, bus.innerEn); end
        tick();
        total++; if (bus.beginCount !== 1'b0 || bus.pumpOn !== 1'b1)
            begin bad++; $display("FAIL evac_pump got begin=%b pump=%b want 0 1", bus.beginCount, bus.pumpOn); end
        bus.evacSw = 1'b0;
        // request while busy is refused and changes nothing
        bus.pressSw = 1'b1;
        tick(); tick();
        total++; if (bus.reqReject !== 1'b1 || bus.pumpOn !== 1'b1)
            begin bad++; $display("FAIL busy_reject got rej=%b pump=%b want 1 1", bus.reqReject, bus.pumpOn); end
        tick();
        total++; if (bus.reqReject !== 1'b0) begin bad++; $display("FAIL busy_reject_pulse got %b want 0", bus.reqReject); end
        bus.pressSw = 1'b0;
        repeat (5) tick();
        total++; if (bus.pumpOn !== 1'b1 || bus.counterSeconds !== 10'd7)
            begin bad++; $display("FAIL evac_hold got pump=%b secs=%0d want 1 7", bus.pumpOn, bus.counterSeconds); end
        bus.countDone = 1'b1;
        tick();
        bus.countDone = 1'b0;
        total++; if (bus.outerEn !== 1'b1 || bus.pumpOn !== 1'b0 || bus.busy !== 1'b0)
            begin bad++; $display("FAIL depressed got outer=%b pump=%b busy=%b want 1 0 0", bus.outerEn, bus.pumpOn, bus.busy); end
        total++; if (bus.counterSeconds !== 10'd7) begin bad++; $display("FAIL secs_retained got %0d want 7", bus.counterSeconds); end
    endtask

    task automatic test_press_cycle();
        bus.pressSw = 1'b1;
        tick(); tick();
        total++; if (bus.beginCount !== 1'b1 || bus.counterSeconds !== 10'd5)
            begin bad++; $display("FAIL press_begin got begin=%b secs=%0d want 1 5", bus.beginCount, bus.counterSeconds); end
        tick();
        total++; if (bus.ventOn !== 1'b1 || bus.beginCount !== 1'b0 || bus.outerEn !== 1'b0)
            begin bad++; $display("FAIL press_vent got vent=%b begin=%b outer=%b want 1 0 0", bus.ventOn, bus.beginCount, bus.outerEn); end
        bus.pressSw = 1'b0;
        repeat (3) tick();
        bus.countDone = 1'b1;
        tick();
        bus.countDone = 1'b0;
        total++; if (bus.innerEn !== 1'b1 || bus.busy !== 1'b0 || bus.ventOn !== 1'b0)
            begin bad++; $display("FAIL pressed got inner=%b busy=%b vent=%b want 1 0 0", bus.innerEn, bus.busy, bus.ventOn); end
        // stray countDone while idle is ignored
        bus.countDone = 1'b1;
        tick();
        bus.countDone = 1'b0;
        tick();
        total++; if (bus.reqReject !== 1'b0 || bus.beginCount !== 1'b0 || bus.innerEn !== 1'b1)
            begin bad++; $display("FAIL stray_done got rej=%b begin=%b inner=%b want 0 0 1", bus.reqReject, bus.beginCount, bus.innerEn); end
    endtask

    task automatic test_reject_door();
        bus.innerOpen = 1'b1;
        bus.evacSw = 1'b1;
        tick(); tick();
        total++; if (bus.reqReject !== 1'b1 || bus.beginCount !== 1'b0)
            begin bad++; $display("FAIL door_reject got rej=%b begin=%b want 1 0", bus.reqReject, bus.beginCount); end
        tick();
        total++; if (bus.reqReject !== 1'b0 || bus.innerEn !== 1'b1 || bus.busy !== 1'b0)
            begin bad++; $display("FAIL door_reject_after got rej=%b inner=%b busy=%b want 0 1 0", bus.reqReject, bus.innerEn, bus.busy); end
        bus.evacSw = 1'b0;
        bus.innerOpen = 1'b0;
        tick();
    endtask

    task automatic test_both_requests();
        bus.evacSw = 1'b1;
        bus.pressSw = 1'b1;
        tick(); tick();
        total++; if (bus.reqReject !== 1'b1 || bus.beginCount !== 1'b0)
            begin bad++; $display("FAIL both_reject got rej=%b begin=%b want 1 0", bus.reqReject, bus.beginCount); end
        tick();
        total++; if (bus.reqReject !== 1'b0 || bus.busy !== 1'b0 || bus.innerEn !== 1'b1)
            begin bad++; $display("FAIL both_after got rej=%b busy=%b inner=%b want 0 0 1", bus.reqReject, bus.busy, bus.innerEn); end
        bus.evacSw = 1'b0;
        bus.pressSw = 1'b0;
        tick();
    endtask

    task automatic test_fault();
        bus.evacSw = 1'b1;
        tick(); tick(); tick();
        bus.evacSw = 1'b0;
        repeat (9) tick();
        total++; if (bus.pumpOn !== 1'b1) begin bad++; $display("FAIL fault_pre_pump got %b want 1", bus.pumpOn); end
        bus.outerOpen = 1'b1;
        bus.countDone = 1'b1;
        tick();
        bus.countDone = 1'b0;
        total++; if (bus.fault !== 1'b1 || bus.pumpOn !== 1'b0 || bus.busy !== 1'b0)
            begin bad++; $display("FAIL fault_enter got fault=%b pump=%b busy=%b want 1 0 0", bus.fault, bus.pumpOn, bus.busy); end
        total++; if (bus.innerEn !== 1'b0 || bus.outerEn !== 1'b0)
            begin bad++; $display("FAIL fault_doors got inner=%b outer=%b want 0 0", bus.innerEn, bus.outerEn); end
        bus.outerOpen = 1'b0;
        tick();
        total++; if (bus.fault !== 1'b1) begin bad++; $display("FAIL fault_hold got %b want 1", bus.fault); end
        bus.pressSw = 1'b1;
        tick(); tick();
        total++; if (bus.beginCount !== 1'b1 || bus.fault !== 1'b0 || bus.counterSeconds !== 10'd5)
            begin bad++; $display("FAIL fault_recover got begin=%b fault=%b secs=%0d want 1 0 5", bus.beginCount, bus.fault, bus.counterSeconds); end
        bus.pressSw = 1'b0;
        tick();
        total++; if (bus.ventOn !== 1'b1) begin bad++; $display("FAIL fault_recover_vent got %b want 1", bus.ventOn); end
    endtask

    task automatic test_reset_mid();
        tick();
        #2;
        Reset = 1'b0;
        #1;
        total++; if (bus.ventOn !== 1'b0 || bus.busy !== 1'b0 || bus.innerEn !== 1'b1)
            begin bad++; $display("FAIL async_rst got vent=%b busy=%b inner=%b want 0 0 1", bus.ventOn, bus.busy, bus.innerEn); end
        total++; if (bus.counterSeconds !== 10'd0 || bus.beginCount !== 1'b0 || bus.fault !== 1'b0)
            begin bad++; $display("FAIL async_rst_regs got secs=%0d begin=%b fault=%b want 0 0 0", bus.counterSeconds, bus.beginCount, bus.fault); end
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        bus.countDone = 1'b1;
        tick();
        bus.countDone = 1'b0;
        tick();
        total++; if (bus.beginCount !== 1'b0 || bus.busy !== 1'b0 || bus.innerEn !== 1'b1 || bus.ventOn !== 1'b0)
            begin bad++; $display("FAIL post_rst_done got begin=%b busy=%b inner=%b vent=%b want 0 0 1 0", bus.beginCount, bus.busy, bus.innerEn, bus.ventOn); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_evac_cycle();
        test_press_cycle();
        test_reject_door();
        test_both_requests();
        test_fault();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
